// File: rtl/wb_cmd_master.sv
// wb_cmd_master
// -------------
// Turns a valid/ready command stream into single Wishbone classic bus
// cycles and returns one response per command. Only one transaction is
// in flight at a time. A transaction that sees no ack within TIMEOUT bus
// cycles is aborted and reported through rsp_err_o.
//
// Parameters
//   TIMEOUT      maximum bus cycles to wait for ack (1..255)
//
// Ports
//   wb_clk_i     clock; all state changes on its rising edge
//   wb_rst_i     synchronous active-high reset
//   cmd_valid_i  command request
//   cmd_ready_o  command acceptance (high only while idle)
//   cmd_we_i     1 = write, 0 = read
//   cmd_adr_i    byte address
//   cmd_dat_i    write data
//   cmd_sel_i    byte lane selects
//   rsp_valid_o  response available
//   rsp_ready_i  response consumed
//   rsp_dat_o    read data (0 for writes and timeouts)
//   rsp_err_o    timeout flag
//   wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
//                Wishbone initiator request
//   wbm_dat_i, wbm_ack_i
//                Wishbone responder return path
module wb_cmd_master #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] wait_cnt;
  logic       accept;
  logic       timeout_hit;

  // Reset is gated into ready so a command presented during reset is never
  // seen as handshaken by the upstream side.
  assign cmd_ready_o = (state == IDLE) && !wb_rst_i;
  assign wbm_cyc_o   = (state == BUS);
  assign wbm_stb_o   = wbm_cyc_o;
  assign rsp_valid_o = (state == RESP);
  assign timeout_hit = (wait_cnt == TIMEOUT_CNT);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Ack takes priority over the timeout, so an ack in the final allowed
  // cycle still completes normally.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid_i) begin
          accept     = 1'b1;
          state_next = BUS;
        end
      end
      BUS: begin
        if (wbm_ack_i || timeout_hit) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Request fields are only loaded on acceptance, which keeps them stable
  // for the whole bus cycle regardless of what cmd_* does meanwhile.
  // The response is only written when leaving BUS, so it stays stable
  // throughout RESP.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= 4'h0;
      wbm_adr_o <= 32'h0;
      wbm_dat_o <= 32'h0;
      rsp_dat_o <= 32'h0;
      rsp_err_o <= 1'b0;
      wait_cnt  <= 8'h0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            wbm_we_o  <= cmd_we_i;
            wbm_sel_o <= cmd_sel_i;
            wbm_adr_o <= cmd_adr_i;
            wbm_dat_o <= cmd_dat_i;
            wait_cnt  <= 8'd1;
          end
        end
        BUS: begin
          if (wbm_ack_i) begin
            rsp_dat_o <= wbm_we_o ? 32'h0 : wbm_dat_i;
            rsp_err_o <= 1'b0;
          end else if (timeout_hit) begin
            rsp_dat_o <= 32'h0;
            rsp_err_o <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master
// ----------------
// Directed bench for wb_cmd_master (TIMEOUT = 16). Each task covers one
// behaviour and checks against hand-computed values. Inputs are driven and
// outputs sampled 1 time unit after the rising edge.
module tb_wb_cmd_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_out;
  logic [31:0] dat_in;
  logic        ack;

  int errors = 0;
  int checks = 0;

  wb_cmd_master #(.TIMEOUT(16)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_we_i    (cmd_we),
    .cmd_adr_i   (cmd_adr),
    .cmd_dat_i   (cmd_dat),
    .cmd_sel_i   (cmd_sel),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_dat_o   (rsp_dat),
    .rsp_err_o   (rsp_err),
    .wbm_cyc_o   (cyc),
    .wbm_stb_o   (stb),
    .wbm_we_o    (we),
    .wbm_sel_o   (sel),
    .wbm_adr_o   (adr),
    .wbm_dat_o   (dat_out),
    .wbm_dat_i   (dat_in),
    .wbm_ack_i   (ack)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a command for exactly one edge; caller must be in IDLE.
  task automatic send_cmd(input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s);
    cmd_we    = w;
    cmd_adr   = a;
    cmd_dat   = d;
    cmd_sel   = s;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    cmd_adr   = 32'h1111_2222;
    cmd_dat   = 32'h3333_4444;
    cmd_sel   = 4'hF;
    rsp_ready = 1'b1;
    ack       = 1'b0;
    dat_in    = 32'h0;
    step();
    step();
    checks++; if (cyc !== 1'b0 || stb !== 1'b0) begin errors++;
      $display("[TB] FAIL reset_cyc got cyc=%b stb=%b expected 0", cyc, stb); end
    checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_dat !== 32'h0) begin errors++;
      $display("[TB] FAIL reset_rsp got valid=%b err=%b dat=%h expected 0", rsp_valid, rsp_err, rsp_dat); end
    checks++; if (adr !== 32'h0 || dat_out !== 32'h0 || sel !== 4'h0 || we !== 1'b0) begin errors++;
      $display("[TB] FAIL reset_fields got adr=%h dat=%h sel=%h we=%b expected 0", adr, dat_out, sel, we); end
    rst       = 1'b0;
    cmd_valid = 1'b0;
    step();
    checks++; if (cmd_ready !== 1'b1 || cyc !== 1'b0) begin errors++;
      $display("[TB] FAIL reset_release got ready=%b cyc=%b expected 1/0", cmd_ready, cyc); end
  endtask

  task automatic test_read_zero_wait();
    rsp_ready = 1'b1;
    checks++; if (cmd_ready !== 1'b1) begin errors++;
      $display("[TB] FAIL read_ready got %b expected 1", cmd_ready); end
    send_cmd(1'b0, 32'h3000_0000, 32'h0, 4'hF);
    checks++; if (cyc !== 1'b1 || stb !== 1'b1 || we !== 1'b0 || adr !== 32'h3000_0000) begin errors++;
      $display("[TB] FAIL read_bus got cyc=%b stb=%b we=%b adr=%h expected 1/1/0/30000000", cyc, stb, we, adr); end
    ack    = 1'b1;
    dat_in = 32'hA5A5_0F0F;
    step();
    ack = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || cyc !== 1'b0 || stb !== 1'b0) begin errors++;
      $display("[TB] FAIL read_rsp_timing got valid=%b cyc=%b expected 1/0", rsp_valid, cyc); end
    checks++; if (rsp_dat !== 32'hA5A5_0F0F || rsp_err !== 1'b0) begin errors++;
      $display("[TB] FAIL read_rsp_data got dat=%h err=%b expected a5a50f0f/0", rsp_dat, rsp_err); end
    checks++; if (cmd_ready !== 1'b0) begin errors++;
      $display("[TB] FAIL read_ready_in_resp got %b expected 0", cmd_ready); end
    step();
    checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++;
      $display("[TB] FAIL read_back_idle got ready=%b valid=%b expected 1/0", cmd_ready, rsp_valid); end
  endtask

  task automatic test_write_wait();
    rsp_ready = 1'b1;
    dat_in    = 32'hDEAD_BEEF;
    send_cmd(1'b1, 32'h3000_0004, 32'h0000_00FF, 4'hF);
    for (int i = 0; i < 4; i++) begin
      // Disturb the command inputs; the bus fields must not follow.
      cmd_we  = 1'b0;
      cmd_adr = 32'h5555_0000 + 32'(i);
      cmd_dat = 32'h1234_0000;
      cmd_sel = 4'h1;
      checks++; if (cyc !== 1'b1 || we !== 1'b1 || adr !== 32'h3000_0004 ||
                    dat_out !== 32'h0000_00FF || sel !== 4'hF) begin errors++;
        $display("[TB] FAIL write_hold cycle %0d got cyc=%b we=%b adr=%h dat=%h sel=%h expected 1/1/30000004/000000ff/f",
                 i, cyc, we, adr, dat_out, sel); end
      ack = (i == 3);
      step();
    end
    ack = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || cyc !== 1'b0 || rsp_dat !== 32'h0 || rsp_err !== 1'b0) begin errors++;
      $display("[TB] FAIL write_rsp got valid=%b cyc=%b dat=%h err=%b expected 1/0/0/0", rsp_valid, cyc, rsp_dat, rsp_err); end
    step();
  endtask

  task automatic test_timeout();
    int n;
    rsp_ready = 1'b1;
    ack       = 1'b0;
    dat_in    = 32'hFFFF_FFFF;
    send_cmd(1'b0, 32'h3000_0008, 32'h0, 4'hF);
    n = 0;
    while (cyc === 1'b1 && n < 40) begin
      n++;
      step();
    end
    checks++; if (n != 16) begin errors++;
      $display("[TB] FAIL timeout_len got %0d cycles expected 16", n); end
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_dat !== 32'h0) begin errors++;
      $display("[TB] FAIL timeout_rsp got valid=%b err=%b dat=%h expected 1/1/0", rsp_valid, rsp_err, rsp_dat); end
    step();
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    send_cmd(1'b0, 32'h3000_000C, 32'h0, 4'hF);
    ack    = 1'b1;
    dat_in = 32'h1234_5678;
    step();
    ack       = 1'b0;
    dat_in    = 32'h0;
    cmd_we    = 1'b0;
    cmd_adr   = 32'h3000_0010;
    cmd_sel   = 4'h3;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_dat !== 32'h1234_5678 || rsp_err !== 1'b0 ||
                    cmd_ready !== 1'b0 || cyc !== 1'b0) begin errors++;
        $display("[TB] FAIL bp_hold cycle %0d got valid=%b dat=%h err=%b ready=%b cyc=%b expected 1/12345678/0/0/0",
                 i, rsp_valid, rsp_dat, rsp_err, cmd_ready, cyc); end
      step();
    end
    rsp_ready = 1'b1;
    checks++; if (rsp_valid !== 1'b1) begin errors++;
      $display("[TB] FAIL bp_still_valid got %b expected 1", rsp_valid); end
    step();
    checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || cyc !== 1'b0) begin errors++;
      $display("[TB] FAIL bp_release got ready=%b valid=%b cyc=%b expected 1/0/0", cmd_ready, rsp_valid, cyc); end
    step();
    cmd_valid = 1'b0;
    checks++; if (cyc !== 1'b1 || adr !== 32'h3000_0010 || sel !== 4'h3) begin errors++;
      $display("[TB] FAIL bp_next_cmd got cyc=%b adr=%h sel=%h expected 1/30000010/3", cyc, adr, sel); end
    ack    = 1'b1;
    dat_in = 32'h0BAD_F00D;
    step();
    ack = 1'b0;
    checks++; if (rsp_dat !== 32'h0BAD_F00D) begin errors++;
      $display("[TB] FAIL bp_next_rsp got %h expected 0badf00d", rsp_dat); end
    step();
  endtask

  task automatic test_ack_at_timeout();
    rsp_ready = 1'b1;
    ack       = 1'b0;
    send_cmd(1'b0, 32'h3000_0014, 32'h0, 4'hF);
    for (int i = 1; i < 16; i++) step();
    checks++; if (cyc !== 1'b1) begin errors++;
      $display("[TB] FAIL edge_cyc16 got %b expected 1", cyc); end
    ack    = 1'b1;
    dat_in = 32'hCAFE_F00D;
    step();
    ack = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_dat !== 32'hCAFE_F00D) begin errors++;
      $display("[TB] FAIL edge_ack16 got valid=%b err=%b dat=%h expected 1/0/cafef00d", rsp_valid, rsp_err, rsp_dat); end
    step();
  endtask

  task automatic test_stray_ack();
    ack    = 1'b1;
    dat_in = 32'h7777_7777;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (rsp_valid !== 1'b0 || cyc !== 1'b0 || cmd_ready !== 1'b1) begin errors++;
        $display("[TB] FAIL stray_ack cycle %0d got valid=%b cyc=%b ready=%b expected 0/0/1", i, rsp_valid, cyc, cmd_ready); end
    end
    ack = 1'b0;
  endtask

  task automatic test_reset_mid_bus();
    rsp_ready = 1'b0;
    send_cmd(1'b1, 32'h3000_0018, 32'hAAAA_5555, 4'hC);
    step();
    rst = 1'b1;
    step();
    checks++; if (cyc !== 1'b0 || stb !== 1'b0 || rsp_valid !== 1'b0) begin errors++;
      $display("[TB] FAIL rst_bus got cyc=%b stb=%b valid=%b expected 0/0/0", cyc, stb, rsp_valid); end
    checks++; if (adr !== 32'h0 || rsp_err !== 1'b0) begin errors++;
      $display("[TB] FAIL rst_bus_clear got adr=%h err=%b expected 0/0", adr, rsp_err); end
    rst    = 1'b0;
    ack    = 1'b1;
    dat_in = 32'h9999_9999;
    step();
    ack = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || cyc !== 1'b0 || cmd_ready !== 1'b1) begin errors++;
      $display("[TB] FAIL rst_late_ack got valid=%b cyc=%b ready=%b expected 0/0/1", rsp_valid, cyc, cmd_ready); end
    step();
    checks++; if (rsp_valid !== 1'b0 || rsp_dat !== 32'h0) begin errors++;
      $display("[TB] FAIL rst_no_rsp got valid=%b dat=%h expected 0/0", rsp_valid, rsp_dat); end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_read_zero_wait();
    test_write_wait();
    test_timeout();
    test_backpressure();
    test_ack_at_timeout();
    test_stray_ack();
    test_reset_mid_bus();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_cmd_master.md
WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of Wishbone bus cycles waited for ack before aborting (legal range 1..255).
REQ-002 SHALL have port wb_clk_i, input, 1, the only clock; all state changes on its rising edge.
REQ-003 SHALL have port wb_rst_i, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port cmd_valid_i, input, 1, command request.
REQ-005 SHALL have port cmd_ready_o, output, 1, command acceptance.
REQ-006 SHALL have port cmd_we_i, input, 1, 1=write, 0=read.
REQ-007 SHALL have port cmd_adr_i, input, 32, byte address.
REQ-008 SHALL have port cmd_dat_i, input, 32, write data.
REQ-009 SHALL have port cmd_sel_i, input, 4, byte lane selects.
REQ-010 SHALL have port rsp_valid_o, output, 1, response available.
REQ-011 SHALL have port rsp_ready_i, input, 1, response consumed.
REQ-012 SHALL have port rsp_dat_o, output, 32, read data (0 for writes and errors).
REQ-013 SHALL have port rsp_err_o, output, 1, timeout flag.
REQ-014 SHALL have ports wbm_cyc_o, wbm_stb_o, wbm_we_o (outputs, 1 each), wbm_sel_o (output, 4), wbm_adr_o (output, 32) and wbm_dat_o (output, 32), forming the Wishbone classic initiator request.
REQ-015 SHALL have ports wbm_dat_i (input, 32) and wbm_ack_i (input, 1), forming the responder return path.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, BUS and RESP.
REQ-017 SHALL drive cmd_ready_o = 1 only in IDLE; a handshake occurs when cmd_valid_i and cmd_ready_o are both high at an edge.
REQ-018 On a handshake in cycle N, SHALL latch we/adr/dat/sel, enter BUS, and present wbm_cyc_o = wbm_stb_o = 1 with the latched fields from cycle N+1.
REQ-019 In BUS, wbm_we_o, wbm_sel_o, wbm_adr_o and wbm_dat_o SHALL be held stable until the cycle is released; cmd_* changes SHALL have no effect.
REQ-020 In BUS, an 8-bit wait counter SHALL start at 1 in the first BUS cycle and increment each BUS cycle without ack.
REQ-021 When wbm_ack_i = 1 is sampled in BUS, SHALL capture rsp_dat_o = wbm_dat_i for reads (0 for writes), set rsp_err_o = 0, deassert cyc/stb at the next edge and enter RESP.
REQ-022 If no ack is sampled by the BUS cycle where counter = TIMEOUT, SHALL deassert cyc/stb at the next edge, set rsp_err_o = 1 and rsp_dat_o = 0, and enter RESP.
REQ-023 If ack and the timeout occur in the same cycle, SHALL treat it as ack (err = 0).
REQ-024 In RESP, SHALL hold rsp_valid_o = 1 and rsp_dat_o / rsp_err_o stable until rsp_ready_i = 1 is sampled, then return to IDLE the following cycle.
REQ-025 Minimum latency SHALL be: handshake at cycle N, ack at cycle N+1, rsp_valid_o at cycle N+2, cmd_ready_o at cycle N+3 at the earliest (with rsp_ready_i held high).
REQ-026 SHALL ignore wbm_ack_i sampled in IDLE or RESP, with no state or data change.
REQ-027 wbm_stb_o SHALL always equal wbm_cyc_o; no pipelined or burst cycles are issued.
REQ-028 Only one outstanding transaction SHALL exist at a time.

Reset
REQ-029 At an edge with wb_rst_i = 1, SHALL enter IDLE and clear all of the following to 0: wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, rsp_valid_o, rsp_dat_o, rsp_err_o and the wait counter.
REQ-030 cmd_valid_i sampled while wb_rst_i = 1 SHALL NOT be accepted.
REQ-031 cmd_ready_o SHALL be 1 from the first edge after wb_rst_i deasserts.
REQ-032 Reset during BUS or RESP SHALL abort the transaction with no response issued; an ack arriving afterwards SHALL be ignored.

Verification
REQ-033 Read, zero-wait: cmd read adr 0x3000_0000; ack with wbm_dat_i = 0xA5A5_0F0F in the first stb cycle -> rsp_valid_o 2 cycles after handshake, rsp_dat_o = 0xA5A5_0F0F, rsp_err_o = 0, cyc deasserted in the same cycle as rsp_valid_o rises.
REQ-034 Write, 3 wait states: cmd we = 1, adr 0x3000_0004, dat 0x0000_00FF, sel 0xF -> wbm_* fields stable for 4 stb cycles, rsp_dat_o = 0, rsp_err_o = 0.
REQ-035 Timeout: TIMEOUT = 16, ack never asserted -> cyc/stb high for exactly 16 cycles, then rsp_err_o = 1 and rsp_dat_o = 0.
REQ-036 Backpressure: rsp_ready_i held low for 5 cycles -> rsp_valid_o and data stable throughout, cmd_ready_o stays 0, and a new cmd_valid_i is not accepted until after rsp_ready_i = 1.
REQ-037 Edge events: ack in the 16th BUS cycle -> err = 0; stray ack in IDLE -> no response; wb_rst_i pulsed mid-BUS -> cyc = 0 next cycle, no rsp_valid_o, cmd_ready_o = 1 after release.
